// File: rtl/spi_ram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : spi_ram_pkg                                                 |
// | Shared SPI opcode constants and RAM port arbiter FSM encodings.       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package spi_ram_pkg;

  // SPI command opcodes carried in the two MSBs of the command word
  localparam logic [1:0] OP_LD_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE      = 2'b01;
  localparam logic [1:0] OP_LD_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_READ       = 2'b11;

  // RAM port FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SPI_ACC  = 2'd1,
    ST_HOST_ACC = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : rr_arb2                                                      |
// | Two-requester round-robin arbiter. Request/grant bit 0 is SPI, bit 1  |
// | is host. Only contested decisions move the pointer, so two requesters |
// | colliding repeatedly alternate; SPI is favoured after reset.          |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // High when the host should win the next contested decision
  logic prefer_host;

  // Grant: single requester wins outright, contention resolved by pointer
  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = prefer_host ? 2'b10 : 2'b01;
    end
  end

  // Pointer flips to the loser whenever a contested grant is consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prefer_host <= 1'b0;
    end else if (update && req[0] && req[1]) begin
      prefer_host <= gnt[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : ram_port_arbiter                                             |
// | Shares one single-port RAM between an SPI command stream and a local  |
// | host. SPI read/write commands are buffered in a one-entry holding     |
// | register; address-load commands bypass the RAM port entirely.         |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  output logic              spi_tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              spi_ovf
);
  import spi_ram_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              hold_valid, hold_wr;
  logic [DATA_W-1:0] hold_data;
  logic              rd_spi;
  logic [1:0]        arb_gnt;

  logic [1:0]        rx_op;
  logic [DATA_W-1:0] rx_payload;
  logic              rx_acc_word, hold_clr, hold_load, rx_drop;

  assign rx_op       = spi_rx_data[DATA_W+1:DATA_W];
  assign rx_payload  = spi_rx_data[DATA_W-1:0];
  assign rx_acc_word = spi_rx_valid && (rx_op == OP_WRITE || rx_op == OP_READ);
  // The holding register frees up in the SPI_ACC cycle, so a word arriving
  // right then still fits.
  assign hold_clr    = (state == ST_SPI_ACC);
  assign hold_load   = rx_acc_word && (!hold_valid || hold_clr);
  assign rx_drop     = rx_acc_word && hold_valid && !hold_clr;

  // SPI request includes an incoming access word so an idle port can
  // start it on the very next cycle (gives the 3-cycle read latency).
  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({host_req, hold_valid || rx_acc_word}),
    .update (state == ST_IDLE),
    .gnt    (arb_gnt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and RAM/grant drive; everything forced low while in reset
  always_comb begin
    state_nx  = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    host_gnt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_gnt[0])      state_nx = ST_SPI_ACC;
        else if (arb_gnt[1]) state_nx = ST_HOST_ACC;
      end
      ST_SPI_ACC: begin
        ram_en    = 1'b1;
        ram_we    = hold_wr;
        ram_addr  = hold_wr ? wr_addr : rd_addr;
        ram_wdata = hold_data;
        state_nx  = hold_wr ? ST_IDLE : ST_RD_WAIT;
      end
      ST_HOST_ACC: begin
        ram_en    = 1'b1;
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        host_gnt  = 1'b1;
        state_nx  = host_we ? ST_IDLE : ST_RD_WAIT;
      end
      ST_RD_WAIT: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (!rst_n) begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      host_gnt  = 1'b0;
    end
  end

  // Address registers loaded directly from SPI, truncated/extended to ADDR_W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (spi_rx_valid) begin
      if (rx_op == OP_LD_WR_ADDR) wr_addr <= ADDR_W'(rx_payload);
      if (rx_op == OP_LD_RD_ADDR) rd_addr <= ADDR_W'(rx_payload);
    end
  end

  // One-entry SPI holding register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_wr    <= 1'b0;
      hold_data  <= '0;
      spi_ovf    <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_wr    <= (rx_op == OP_WRITE);
        hold_data  <= rx_payload;
      end else if (hold_clr) begin
        hold_valid <= 1'b0;
      end
      if (rx_drop) spi_ovf <= 1'b1;
    end
  end

  // Read-data return: route captured RAM data to whichever side issued it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_spi       <= 1'b0;
      spi_tx_valid <= 1'b0;
      spi_tx_data  <= '0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      rd_spi      <= (state == ST_SPI_ACC);
      host_rvalid <= 1'b0;
      if (state == ST_RD_WAIT) begin
        if (rd_spi) begin
          spi_tx_valid <= 1'b1;
          spi_tx_data  <= ram_rdata;
        end else begin
          host_rvalid  <= 1'b1;
          host_rdata   <= ram_rdata;
        end
      end
      // A newly accepted SPI read invalidates the previous result
      if (hold_load && rx_op == OP_READ) spi_tx_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_ram_port_arbiter                                          |
// | Directed self-checking bench for ram_port_arbiter with a RAM model.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic       spi_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .spi_ovf      (spi_ovf)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_ctl"}, {27'd0, spi_tx_valid, host_gnt, host_rvalid, ram_en, spi_ovf}, 32'd0);
    check({tag, "_data"}, {16'd0, spi_tx_data, host_rdata}, 32'd0);
  endtask

  task automatic spi_word(input logic [9:0] w);
    spi_rx_data  = w;
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!host_gnt && cyc < 20);
  endtask

  task automatic contend_round(output logic [7:0] first, output logic [7:0] second, output int n);
    n = 0; first = '0; second = '0;
    spi_rx_data  = 10'h1A5; spi_rx_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      spi_rx_valid = 1'b0;
      if (ram_en) begin
        if (n == 0)      first  = ram_addr;
        else if (n == 1) second = ram_addr;
        n++;
      end
      if (host_gnt) host_req = 1'b0;
    end
  endtask

  int         cyc, n_en, wr_cnt;
  logic [7:0] a0, a1, wr_data, wr_addr_seen;

  initial begin
    rst_n = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outs_zero("post_reset");

    // SPI write: load wr_addr 0x05, then write 0xA5
    spi_word(10'h005);
    check("ld_addr_no_ram", {31'd0, ram_en}, 32'd0);
    spi_word(10'h1A5);
    check("spi_wr_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h05, 8'hA5});
    n_en = 0;
    repeat (4) begin @(negedge clk); if (ram_en) n_en++; end
    check("spi_wr_single", n_en, 0);
    check("spi_wr_mem", {24'd0, mem[8'h05]}, 32'h0000_00A5);

    // SPI read: load rd_addr 0x05, read; data three cycles after strobe
    spi_word(10'h205);
    spi_word(10'h300);
    check("spi_rd_cmd", {ram_en, ram_we, ram_addr}, {2'b10, 8'h05});
    @(negedge clk);
    check("spi_rd_not_yet", {31'd0, spi_tx_valid}, 32'd0);
    @(negedge clk);
    check("spi_rd_result", {spi_tx_valid, spi_tx_data}, {1'b1, 8'hA5});
    repeat (2) @(negedge clk);
    check("spi_tx_held", {31'd0, spi_tx_valid}, 32'd1);

    // Host read of 0x05: grant, then rvalid two cycles later
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    wait_gnt(cyc);
    check("host_gnt_lat", cyc, 1);
    host_req = 1'b0;
    @(negedge clk);
    check("host_rvalid_early", {31'd0, host_rvalid}, 32'd0);
    @(negedge clk);
    check("host_rd_result", {host_rvalid, host_rdata}, {1'b1, 8'hA5});
    @(negedge clk);
    check("host_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);

    // Contention twice: SPI then host, then host then SPI
    contend_round(a0, a1, n_en);
    check("rr1_count", n_en, 2);
    check("rr1_order", {16'd0, a0, a1}, 32'h0000_0510);
    contend_round(a0, a1, n_en);
    check("rr2_count", n_en, 2);
    check("rr2_order", {16'd0, a0, a1}, 32'h0000_1005);
    check("host_wr_mem", {24'd0, mem[8'h10]}, 32'h0000_003C);

    // Overflow: host reading continuously, two SPI writes back-to-back
    spi_word(10'h020);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    wait_gnt(cyc);
    check("ovf_gnt_seen", {31'd0, host_gnt}, 32'd1);
    spi_rx_data = 10'h111; spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_data = 10'h122;
    check("ovf_not_yet", {31'd0, spi_ovf}, 32'd0);
    @(negedge clk);
    spi_rx_valid = 1'b0;
    check("ovf_set", {31'd0, spi_ovf}, 32'd1);
    wr_cnt = 0; wr_data = '0; wr_addr_seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ram_en && ram_we) begin
        wr_cnt++; wr_data = ram_wdata; wr_addr_seen = ram_addr;
      end
    end
    check("ovf_one_write", wr_cnt, 1);
    check("ovf_write_cmd", {16'd0, wr_addr_seen, wr_data}, 32'h0000_2011);
    host_req = 1'b0;
    repeat (4) @(negedge clk);
    check("ovf_sticky", {31'd0, spi_ovf}, 32'd1);

    // Reset asserted while an SPI read is in RD_WAIT
    spi_word(10'h300);
    check("rst_rd_cmd", {ram_en, ram_we, ram_addr}, {2'b10, 8'h05});
    check("tx_clr_on_accept", {31'd0, spi_tx_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_during_ram_en", {30'd0, ram_en, host_gnt}, 32'd0);
    @(negedge clk);
    check_outs_zero("rst_in_rdwait");
    rst_n = 1'b1;
    @(negedge clk);
    check_outs_zero("rst_release");
    @(negedge clk);
    check("rst_no_late_valid", {30'd0, spi_tx_valid, host_rvalid}, 32'd0);

    // Port is idle after reset: host read of 0x10 granted immediately
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    wait_gnt(cyc);
    check("post_rst_gnt_lat", cyc, 1);
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_host_rd", {host_rvalid, host_rdata}, {1'b1, 8'h3C});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
